// File: rtl/noc_flit_pkg.sv
// Shared single-flit NoC format: field positions, decoded view, sink FIFO entry and sink FSM states.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package noc_flit_pkg;

    localparam int FLIT_W     = 40;
    localparam int TS_W       = 32;
    localparam int MARKER_B   = 39;
    localparam int SINGLE_B   = 38;
    localparam int RSVD_B     = 32;
    localparam int DEST_LSB   = 33;
    localparam int DEST_MAX_W = SINGLE_B - DEST_LSB;

    // Decoded view of one flit; bit layout matches the wire format exactly.
    typedef struct packed {
        logic                  marker;
        logic                  single;
        logic [DEST_MAX_W-1:0] dest;
        logic                  rsvd;
        logic [TS_W-1:0]       ts;
    } flit_fields_t;

    // One receive-buffer entry: format/route verdict plus the latency measured at accept.
    typedef struct packed {
        logic            err;
        logic [TS_W-1:0] lat;
    } sink_entry_t;

    localparam int SINK_ENTRY_W = $bits(sink_entry_t);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } sink_state_t;

    function automatic flit_fields_t flit_decode(input logic [FLIT_W-1:0] f);
        flit_fields_t r;
        r.marker = f[MARKER_B];
        r.single = f[SINGLE_B];
        r.dest   = f[SINGLE_B-1:DEST_LSB];
        r.rsvd   = f[RSVD_B];
        r.ts     = f[TS_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// Synchronous show-ahead FIFO holding checked flit entries between accept and retire.
// Latency: written entry is visible at rd_dat the cycle after the write edge.
// Backpressure: full blocks writes, empty blocks reads; caller gates on the flags.
module sink_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO regardless of stored data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en && !empty) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/pe_traffic_sink.sv
// PE receive sink: checks flits, measures latency against a free-running counter, accumulates stats.
// Latency: accept to visible stat >= 2 cycles (1 in FIFO, 1 registered retire); optional SINK_HISTOGRAM_EN adds latency bins.
// Backpressure: o_data_ready = !fifo_full (0 in reset); i_sink_en low or i_done stalls retire, FIFO then fills.
module pe_traffic_sink
    import noc_flit_pkg::*;
#(
    parameter int ADDRESS      = 0,
    parameter int AddressWidth = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int LAT_SUM_W    = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_W-1:0]    i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    input  logic                 i_sink_en,
    input  logic                 i_done,
    output logic [31:0]          o_pkt_count,
    output logic [15:0]          o_err_count,
    output logic [LAT_SUM_W-1:0] o_lat_sum,
    output logic [31:0]          o_lat_min,
    output logic [31:0]          o_lat_max,
    input  logic [2:0]           i_hist_sel,
    output logic [31:0]          o_hist_count
);

    localparam logic [AddressWidth-1:0] MY_ADDR = ADDRESS[AddressWidth-1:0];

    logic [31:0]  cnt_q;
    logic         ready_q;
    logic         done_q;
    sink_state_t  state_q;
    sink_state_t  state_d;
    logic         pop_en;
    logic         pop;
    logic         accept;
    logic         fifo_full;
    logic         fifo_empty;
    flit_fields_t flit_f;
    sink_entry_t  wr_entry;
    sink_entry_t  head;

    assign flit_f       = flit_decode(i_data);
    assign o_data_ready = ready_q & ~fifo_full;
    assign accept       = i_data_valid & o_data_ready;

    // Latency is taken modulo 2^32 so a timestamp from before a counter wrap still measures correctly.
    assign wr_entry.err = ~flit_f.marker | ~flit_f.single | flit_f.rsvd
                          | (flit_f.dest[AddressWidth-1:0] != MY_ADDR);
    assign wr_entry.lat = cnt_q - flit_f.ts;

    // Free-running cycle counter and the ready gate that holds off traffic during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 32'd1;
            ready_q <= 1'b1;
            done_q  <= i_done | done_q;
        end
    end

    sink_fifo #(
        .WIDTH (SINK_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_dat (wr_entry),
        .rd_en  (pop),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Run-state register; FROZEN is only left through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and retire permission; done_q also blocks the pop on the edge that enters FROZEN.
    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        case (state_q)
            ST_RUN: begin
                pop_en = ~done_q;
                if (done_q) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                pop_en = 1'b0;
            end
            default: begin
                state_d = ST_FROZEN;
            end
        endcase
    end

    assign pop = pop_en & i_sink_en & ~fifo_empty;

    // Statistics update on retire; errors never touch the latency stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pkt_count <= '0;
            o_err_count <= '0;
            o_lat_sum   <= '0;
            o_lat_min   <= 32'hFFFF_FFFF;
            o_lat_max   <= '0;
        end else if (pop) begin
            if (head.err) begin
                if (o_err_count != 16'hFFFF) begin
                    o_err_count <= o_err_count + 16'd1;
                end
            end else begin
                o_pkt_count <= o_pkt_count + 32'd1;
                o_lat_sum   <= o_lat_sum + LAT_SUM_W'(head.lat);
                if (head.lat < o_lat_min) begin
                    o_lat_min <= head.lat;
                end
                if (head.lat > o_lat_max) begin
                    o_lat_max <= head.lat;
                end
            end
        end
    end

`ifdef SINK_HISTOGRAM_EN
    logic [31:0] hist_q [8];

    // Bin k covers [2^(k+2), 2^(k+3)); the end bins absorb everything below 8 and from 512 up.
    function automatic logic [2:0] hist_bin(input logic [31:0] lat);
        logic [2:0] b;
        b = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (lat >= (32'd1 << (k + 2))) begin
                b = 3'(k);
            end
        end
        return b;
    endfunction

    // Histogram bins advance together with the good-packet count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                hist_q[k] <= '0;
            end
        end else if (pop && !head.err) begin
            hist_q[hist_bin(head.lat)] <= hist_q[hist_bin(head.lat)] + 32'd1;
        end
    end

    assign o_hist_count = hist_q[i_hist_sel];
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^i_hist_sel;
    assign o_hist_count    = '0;
`endif

endmodule
